// File: rtl/uart_rx_fifo_pkg.sv
// Shared definitions for the UART receive path.
// Contents:
//   DEF_DEPTH_LOG2 - default FIFO depth exponent (16 entries)
//   BYTE_W         - width of one received character
//   parity_e       - parity type encodings used by the deserializer and transmitter
//   status_bit_e   - bit positions of the receive status bits in the register map
package uart_rx_fifo_pkg;

  localparam int DEF_DEPTH_LOG2 = 4;
  localparam int BYTE_W         = 8;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2,
    PAR_MARK = 2'd3
  } parity_e;

  typedef enum int {
    ST_OVR   = 0,
    ST_FERR  = 1,
    ST_PERR  = 2,
    ST_VALID = 3,
    ST_FULL  = 4
  } status_bit_e;

endpackage

// File: rtl/uart_fifo_ram.sv
// Byte-wide storage for the receive FIFO: one write port, one read port,
// synchronous write and registered read, so it maps onto block RAM or LUT RAM.
// A read of the address being written in the same cycle returns the old data;
// the FIFO control logic bypasses that case itself.
// Ports:
//   clk      system clock
//   i_we     write enable
//   i_waddr  write address
//   i_wdata  write data
//   i_raddr  read address (sampled every cycle)
//   o_rdata  registered read data, valid the cycle after i_raddr
module uart_fifo_ram
  import uart_rx_fifo_pkg::*;
#(
  parameter int ADDR_W = DEF_DEPTH_LOG2
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [BYTE_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [BYTE_W-1:0] o_rdata
);

  logic [BYTE_W-1:0] r_mem [2**ADDR_W];
  logic [BYTE_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive buffer behind the UART RX deserializer. Accepted bytes go into a
// first-word-fall-through FIFO that the register side drains; sticky overrun,
// framing and parity flags are kept, and a registered interrupt is raised on
// fill level or on any sticky error.
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   rx_byte_i       received byte, qualified by rx_en_i
//   rx_en_i         one-cycle push strobe
//   frame_err_i     one-cycle framing error strobe
//   parity_err_i    one-cycle parity error strobe
//   rd_en_i         one-cycle pop strobe (ignored when empty)
//   rd_data_o       head entry, 0 when empty
//   rd_valid_o      FIFO not empty
//   full_o          FIFO holds DEPTH entries
//   count_o         fill level 0..DEPTH
//   flush_i         one-cycle strobe discarding all entries
//   thr_i           fill-level interrupt threshold, 0 disables it
//   err_irq_en_i    lets sticky errors drive the interrupt
//   clr_err_i       one-cycle strobe clearing the sticky flags
//   overrun_o       sticky: a byte was dropped on a full FIFO
//   frame_err_o     sticky framing error
//   parity_err_o    sticky parity error
//   irq_o           registered level interrupt
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [BYTE_W-1:0]   rx_byte_i,
  input  logic                rx_en_i,
  input  logic                frame_err_i,
  input  logic                parity_err_i,
  input  logic                rd_en_i,
  output logic [BYTE_W-1:0]   rd_data_o,
  output logic                rd_valid_o,
  output logic                full_o,
  output logic [DEPTH_LOG2:0] count_o,
  input  logic                flush_i,
  input  logic [DEPTH_LOG2:0] thr_i,
  input  logic                err_irq_en_i,
  input  logic                clr_err_i,
  output logic                overrun_o,
  output logic                frame_err_o,
  output logic                parity_err_o,
  output logic                irq_o
);

  localparam int                   CW      = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0]        DEPTH_C = CW'(2**DEPTH_LOG2);
  localparam logic [CW-1:0]        CNT_ONE = CW'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

  logic [DEPTH_LOG2-1:0] r_wr_ptr, r_rd_ptr;
  logic [DEPTH_LOG2-1:0] w_wr_ptr_next, w_rd_ptr_next;
  logic [CW-1:0]         r_count, w_count_next;
  logic                  w_full, w_push, w_pop, w_ovr_set, w_byp;
  logic                  r_valid, r_byp_sel, r_ovr, r_ferr, r_perr, r_irq;
  logic                  w_ovr_next, w_ferr_next, w_perr_next, w_lvl_hit, w_irq_next;
  logic [BYTE_W-1:0]     r_byp_data, w_ram_q;

  assign w_full = (r_count == DEPTH_C);

  // A pop on a full FIFO frees the slot the push needs, so push+pop on full is legal.
  assign w_push    = rx_en_i && (!w_full || rd_en_i) && !flush_i;
  assign w_pop     = rd_en_i && (r_count != '0) && !flush_i;
  assign w_ovr_set = rx_en_i && w_full && !rd_en_i;

  always_comb begin
    w_wr_ptr_next = r_wr_ptr;
    w_rd_ptr_next = r_rd_ptr;
    w_count_next  = r_count;
    if (flush_i) begin
      w_wr_ptr_next = '0;
      w_rd_ptr_next = '0;
      w_count_next  = '0;
    end else begin
      if (w_push) w_wr_ptr_next = r_wr_ptr + PTR_ONE;
      if (w_pop)  w_rd_ptr_next = r_rd_ptr + PTR_ONE;
      if (w_push && !w_pop)      w_count_next = r_count + CNT_ONE;
      else if (w_pop && !w_push) w_count_next = r_count - CNT_ONE;
    end
  end

  // Setting pulses win over a simultaneous clear.
  assign w_ovr_next  = w_ovr_set    || (r_ovr  && !clr_err_i);
  assign w_ferr_next = frame_err_i  || (r_ferr && !clr_err_i);
  assign w_perr_next = parity_err_i || (r_perr && !clr_err_i);

  assign w_lvl_hit  = (thr_i != '0) && (w_count_next >= thr_i);
  assign w_irq_next = w_lvl_hit ||
                      (err_irq_en_i && (w_ovr_next || w_ferr_next || w_perr_next));

  // The RAM read port always looks at next cycle's head. When the byte being
  // written is itself that head (push into empty, or push+pop at count 1) the
  // RAM would return stale data, so the byte is forwarded from a side register.
  assign w_byp = w_push && (r_wr_ptr == w_rd_ptr_next);

  uart_fifo_ram #(
    .ADDR_W (DEPTH_LOG2)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr),
    .i_wdata (rx_byte_i),
    .i_raddr (w_rd_ptr_next),
    .o_rdata (w_ram_q)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_valid   <= 1'b0;
      r_byp_sel <= 1'b0;
      r_ovr     <= 1'b0;
      r_ferr    <= 1'b0;
      r_perr    <= 1'b0;
      r_irq     <= 1'b0;
    end else begin
      r_wr_ptr  <= w_wr_ptr_next;
      r_rd_ptr  <= w_rd_ptr_next;
      r_count   <= w_count_next;
      r_valid   <= (w_count_next != '0);
      r_byp_sel <= w_byp;
      r_ovr     <= w_ovr_next;
      r_ferr    <= w_ferr_next;
      r_perr    <= w_perr_next;
      r_irq     <= w_irq_next;
    end
  end

  always_ff @(posedge clk) begin
    if (w_byp) begin
      r_byp_data <= rx_byte_i;
    end
  end

  assign rd_data_o    = r_valid ? (r_byp_sel ? r_byp_data : w_ram_q) : '0;
  assign rd_valid_o   = r_valid;
  assign full_o       = w_full;
  assign count_o      = r_count;
  assign overrun_o    = r_ovr;
  assign frame_err_o  = r_ferr;
  assign parity_err_o = r_perr;
  assign irq_o        = r_irq;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo (DEPTH_LOG2 = 4, 16 entries).
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_byte_i;
  logic       rx_en_i, frame_err_i, parity_err_i, rd_en_i;
  logic [7:0] rd_data_o;
  logic       rd_valid_o, full_o;
  logic [4:0] count_o;
  logic       flush_i;
  logic [4:0] thr_i;
  logic       err_irq_en_i, clr_err_i;
  logic       overrun_o, frame_err_o, parity_err_o, irq_o;

  int checks = 0;
  int errors = 0;

  uart_rx_fifo #(.DEPTH_LOG2(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_byte_i    (rx_byte_i),
    .rx_en_i      (rx_en_i),
    .frame_err_i  (frame_err_i),
    .parity_err_i (parity_err_i),
    .rd_en_i      (rd_en_i),
    .rd_data_o    (rd_data_o),
    .rd_valid_o   (rd_valid_o),
    .full_o       (full_o),
    .count_o      (count_o),
    .flush_i      (flush_i),
    .thr_i        (thr_i),
    .err_irq_en_i (err_irq_en_i),
    .clr_err_i    (clr_err_i),
    .overrun_o    (overrun_o),
    .frame_err_o  (frame_err_o),
    .parity_err_o (parity_err_o),
    .irq_o        (irq_o)
  );

  always #5 clk = ~clk;

  // ctl: {rx_en, rd_en, flush, frame_err, parity_err, clr_err, err_irq_en}
  // flg: {rd_valid, full, overrun, frame_err, parity_err, irq}
  typedef struct {
    logic [6:0] ctl;
    logic [7:0] b;
    logic [4:0] thr;
    logic [4:0] e_cnt;
    logic [7:0] e_dat;
    logic [5:0] e_flg;
  } vec_t;

  vec_t vecs[31];

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    rx_en_i = 1'b0; rx_byte_i = 8'h00; rd_en_i = 1'b0; flush_i = 1'b0;
    frame_err_i = 1'b0; parity_err_i = 1'b0; clr_err_i = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    rx_en_i = 1'b1; rx_byte_i = b;
    step();
    idle_inputs();
  endtask

  task automatic pop();
    rd_en_i = 1'b1;
    step();
    idle_inputs();
  endtask

  initial begin
    vecs[0]  = '{7'b1000000, 8'h41, 5'd0, 5'd1, 8'h41, 6'b100000};
    vecs[1]  = '{7'b0000000, 8'h00, 5'd0, 5'd1, 8'h41, 6'b100000};
    vecs[2]  = '{7'b1000000, 8'h42, 5'd0, 5'd2, 8'h41, 6'b100000};
    vecs[3]  = '{7'b0000000, 8'h00, 5'd0, 5'd2, 8'h41, 6'b100000};
    vecs[4]  = '{7'b1000000, 8'h43, 5'd0, 5'd3, 8'h41, 6'b100000};
    vecs[5]  = '{7'b0100000, 8'h00, 5'd0, 5'd2, 8'h42, 6'b100000};
    vecs[6]  = '{7'b0100000, 8'h00, 5'd0, 5'd1, 8'h43, 6'b100000};
    vecs[7]  = '{7'b0100000, 8'h00, 5'd0, 5'd0, 8'h00, 6'b000000};
    vecs[8]  = '{7'b0100000, 8'h00, 5'd0, 5'd0, 8'h00, 6'b000000};
    vecs[9]  = '{7'b1000000, 8'hA0, 5'd4, 5'd1, 8'hA0, 6'b100000};
    vecs[10] = '{7'b1000000, 8'hA1, 5'd4, 5'd2, 8'hA0, 6'b100000};
    vecs[11] = '{7'b1000000, 8'hA2, 5'd4, 5'd3, 8'hA0, 6'b100000};
    vecs[12] = '{7'b1000000, 8'hA3, 5'd4, 5'd4, 8'hA0, 6'b100001};
    vecs[13] = '{7'b0100000, 8'h00, 5'd4, 5'd3, 8'hA1, 6'b100000};
    vecs[14] = '{7'b0010000, 8'h00, 5'd0, 5'd0, 8'h00, 6'b000000};
    vecs[15] = '{7'b0001010, 8'h00, 5'd0, 5'd0, 8'h00, 6'b000100};
    vecs[16] = '{7'b0000001, 8'h00, 5'd0, 5'd0, 8'h00, 6'b000101};
    vecs[17] = '{7'b0000011, 8'h00, 5'd0, 5'd0, 8'h00, 6'b000000};
    vecs[18] = '{7'b0000100, 8'h00, 5'd0, 5'd0, 8'h00, 6'b000010};
    vecs[19] = '{7'b0000010, 8'h00, 5'd0, 5'd0, 8'h00, 6'b000000};
    vecs[20] = '{7'b1000000, 8'h10, 5'd0, 5'd1, 8'h10, 6'b100000};
    vecs[21] = '{7'b1000000, 8'h11, 5'd0, 5'd2, 8'h10, 6'b100000};
    vecs[22] = '{7'b1000000, 8'h12, 5'd0, 5'd3, 8'h10, 6'b100000};
    vecs[23] = '{7'b1000000, 8'h13, 5'd0, 5'd4, 8'h10, 6'b100000};
    vecs[24] = '{7'b1000000, 8'h14, 5'd0, 5'd5, 8'h10, 6'b100000};
    vecs[25] = '{7'b1010000, 8'h99, 5'd0, 5'd0, 8'h00, 6'b000000};
    vecs[26] = '{7'b1000000, 8'h55, 5'd0, 5'd1, 8'h55, 6'b100000};
    vecs[27] = '{7'b0100000, 8'h00, 5'd0, 5'd0, 8'h00, 6'b000000};
    vecs[28] = '{7'b1100000, 8'h66, 5'd0, 5'd1, 8'h66, 6'b100000};
    vecs[29] = '{7'b1100000, 8'h67, 5'd0, 5'd1, 8'h67, 6'b100000};
    vecs[30] = '{7'b0100000, 8'h00, 5'd0, 5'd0, 8'h00, 6'b000000};

    idle_inputs();
    thr_i = 5'd0;
    err_irq_en_i = 1'b0;
    reset = 1'b1;
    step();
    step();

    chk("rst.count", 8'(count_o), 8'd0);
    chk("rst.valid", 8'(rd_valid_o), 8'd0);
    chk("rst.data",  rd_data_o, 8'h00);
    chk("rst.full",  8'(full_o), 8'd0);
    chk("rst.ovr",   8'(overrun_o), 8'd0);
    chk("rst.ferr",  8'(frame_err_o), 8'd0);
    chk("rst.perr",  8'(parity_err_o), 8'd0);
    chk("rst.irq",   8'(irq_o), 8'd0);
    reset = 1'b0;

    for (int i = 0; i < 31; i++) begin
      rx_en_i      = vecs[i].ctl[6];
      rd_en_i      = vecs[i].ctl[5];
      flush_i      = vecs[i].ctl[4];
      frame_err_i  = vecs[i].ctl[3];
      parity_err_i = vecs[i].ctl[2];
      clr_err_i    = vecs[i].ctl[1];
      err_irq_en_i = vecs[i].ctl[0];
      rx_byte_i    = vecs[i].b;
      thr_i        = vecs[i].thr;
      step();
      chk($sformatf("v%0d.count", i), 8'(count_o), 8'(vecs[i].e_cnt));
      chk($sformatf("v%0d.data", i),  rd_data_o, vecs[i].e_dat);
      chk($sformatf("v%0d.valid", i), 8'(rd_valid_o), 8'(vecs[i].e_flg[5]));
      chk($sformatf("v%0d.full", i),  8'(full_o), 8'(vecs[i].e_flg[4]));
      chk($sformatf("v%0d.ovr", i),   8'(overrun_o), 8'(vecs[i].e_flg[3]));
      chk($sformatf("v%0d.ferr", i),  8'(frame_err_o), 8'(vecs[i].e_flg[2]));
      chk($sformatf("v%0d.perr", i),  8'(parity_err_o), 8'(vecs[i].e_flg[1]));
      chk($sformatf("v%0d.irq", i),   8'(irq_o), 8'(vecs[i].e_flg[0]));
    end
    idle_inputs();
    thr_i = 5'd0;
    err_irq_en_i = 1'b0;

    // Fill to 16, then one more push overruns and is dropped.
    for (int i = 0; i < 16; i++) push(8'(i));
    chk("fill.count", 8'(count_o), 8'd16);
    chk("fill.full",  8'(full_o), 8'd1);
    chk("fill.ovr",   8'(overrun_o), 8'd0);
    push(8'h10);
    chk("ovr.flag",  8'(overrun_o), 8'd1);
    chk("ovr.count", 8'(count_o), 8'd16);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("drain%0d", i), rd_data_o, 8'(i));
      pop();
    end
    chk("drain.count", 8'(count_o), 8'd0);
    chk("drain.valid", 8'(rd_valid_o), 8'd0);
    clr_err_i = 1'b1;
    step();
    idle_inputs();
    chk("ovr.clr", 8'(overrun_o), 8'd0);

    // Full FIFO with simultaneous push and pop.
    for (int i = 0; i < 16; i++) push(8'(8'h20 + i));
    rx_en_i = 1'b1; rx_byte_i = 8'hEE; rd_en_i = 1'b1;
    step();
    idle_inputs();
    chk("pp.count", 8'(count_o), 8'd16);
    chk("pp.ovr",   8'(overrun_o), 8'd0);
    chk("pp.full",  8'(full_o), 8'd1);
    chk("pp.head",  rd_data_o, 8'h21);
    thr_i = 5'd17;
    step();
    chk("thr17.irq", 8'(irq_o), 8'd0);
    thr_i = 5'd16;
    step();
    chk("thr16.irq", 8'(irq_o), 8'd1);
    thr_i = 5'd0;
    for (int i = 0; i < 15; i++) begin
      chk($sformatf("pp.drain%0d", i), rd_data_o, 8'(8'h21 + i));
      pop();
    end
    chk("pp.tail", rd_data_o, 8'hEE);
    pop();
    chk("pp.empty", 8'(count_o), 8'd0);

    // Reset in the middle of filling.
    push(8'h77);
    push(8'h78);
    push(8'h79);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mrst.count", 8'(count_o), 8'd0);
    chk("mrst.valid", 8'(rd_valid_o), 8'd0);
    chk("mrst.data",  rd_data_o, 8'h00);
    chk("mrst.full",  8'(full_o), 8'd0);
    push(8'h55);
    chk("mrst.push.count", 8'(count_o), 8'd1);
    chk("mrst.push.data",  rd_data_o, 8'h55);
    chk("mrst.push.valid", 8'(rd_valid_o), 8'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
